// File: rtl/bp_pkg.sv
// rtl/bp_pkg.sv - shared types and constants for the bimodal branch predictor
package bp_pkg;

  typedef logic [1:0] ctr_t;

  localparam ctr_t CTR_SNT = 2'b00;
  localparam ctr_t CTR_WNT = 2'b01;
  localparam ctr_t CTR_WT  = 2'b10;
  localparam ctr_t CTR_ST  = 2'b11;

  localparam logic [31:0] MISPRED_SAT = 32'hFFFF_FFFF;

  function automatic logic ctr_predict(input ctr_t c);
    return c[1];
  endfunction

endpackage

// File: rtl/branch_predictor_if.sv
// rtl/branch_predictor_if.sv - fetch/execute bus of the branch predictor
// BP_GSHARE_EN adds PredGhr/ResGhr to the bus.
interface branch_predictor_if #(
  parameter int XLEN  = 64,
  parameter int IDX_W = 6
);
  logic            PredValid;
  logic [XLEN-1:0] PredPC;
  logic            PredOutValid;
  logic            PredTaken;
  logic            ResValid;
  logic [XLEN-1:0] ResPC;
  logic            ResTaken;
  logic            ResPredTaken;
  logic            Mispredict;
  logic [31:0]     MispredCount;
`ifdef BP_GSHARE_EN
  logic [IDX_W-1:0] PredGhr;
  logic [IDX_W-1:0] ResGhr;

  modport master (
    output PredValid, PredPC, ResValid, ResPC, ResTaken, ResPredTaken, ResGhr,
    input  PredOutValid, PredTaken, Mispredict, MispredCount, PredGhr
  );
  modport slave (
    input  PredValid, PredPC, ResValid, ResPC, ResTaken, ResPredTaken, ResGhr,
    output PredOutValid, PredTaken, Mispredict, MispredCount, PredGhr
  );
`else
  modport master (
    output PredValid, PredPC, ResValid, ResPC, ResTaken, ResPredTaken,
    input  PredOutValid, PredTaken, Mispredict, MispredCount
  );
  modport slave (
    input  PredValid, PredPC, ResValid, ResPC, ResTaken, ResPredTaken,
    output PredOutValid, PredTaken, Mispredict, MispredCount
  );
`endif
endinterface

// File: rtl/sat_counter2.sv
// rtl/sat_counter2.sv - 2-bit saturating counter next-state function
module sat_counter2
  import bp_pkg::*;
(
  input  ctr_t cur,
  input  logic taken,
  output ctr_t nxt
);

  always_comb begin
    nxt = cur;
    if (taken) begin
      if (cur != CTR_ST) nxt = cur + 2'd1;
    end else begin
      if (cur != CTR_SNT) nxt = cur - 2'd1;
    end
  end

endmodule

// File: rtl/branch_predictor.sv
// rtl/branch_predictor.sv - bimodal predictor with 2-bit counters and mispredict counting
// BP_GSHARE_EN switches indexing to PC xor global history.
module branch_predictor
  import bp_pkg::*;
#(
  parameter int   XLEN       = 64,
  parameter int   IDX_W      = 6,
  parameter ctr_t INIT_STATE = CTR_WNT
) (
  input logic               clk,
  input logic               rst,
  branch_predictor_if.slave bp
);

  localparam int ENTRIES = 1 << IDX_W;

  ctr_t table_q [ENTRIES];
  ctr_t table_d [ENTRIES];

  logic        pred_out_valid_q, pred_out_valid_d;
  logic        pred_taken_q,     pred_taken_d;
  logic        mispredict_q,     mispredict_d;
  logic [31:0] mispred_count_q,  mispred_count_d;

  logic [IDX_W-1:0] pred_idx;
  logic [IDX_W-1:0] res_idx;
  ctr_t             res_cur;
  ctr_t             res_next;

`ifdef BP_GSHARE_EN
  logic [IDX_W-1:0] ghr_q,      ghr_d;
  logic [IDX_W-1:0] pred_ghr_q, pred_ghr_d;

  // Prediction sees the pre-shift history even when a resolve lands this cycle.
  always_comb begin
    pred_idx = bp.PredValid ? (bp.PredPC[IDX_W+1:2] ^ ghr_q) : '0;
    res_idx  = bp.ResPC[IDX_W+1:2] ^ bp.ResGhr;
  end
`else
  always_comb begin
    pred_idx = bp.PredValid ? bp.PredPC[IDX_W+1:2] : '0;
    res_idx  = bp.ResPC[IDX_W+1:2];
  end
`endif

  assign res_cur = table_q[res_idx];

  sat_counter2 u_ctr (
    .cur   (res_cur),
    .taken (bp.ResTaken),
    .nxt   (res_next)
  );

  always_comb begin
    table_d = table_q;
    if (bp.ResValid) table_d[res_idx] = res_next;
  end

  // Reading table_d gives the write-first bypass for a same-index resolve.
  always_comb begin
    pred_out_valid_d = bp.PredValid;
    pred_taken_d     = bp.PredValid ? ctr_predict(table_d[pred_idx]) : 1'b0;
    mispredict_d     = bp.ResValid & (bp.ResTaken != bp.ResPredTaken);
    mispred_count_d  = mispred_count_q;
    if (mispredict_d && (mispred_count_q != MISPRED_SAT)) begin
      mispred_count_d = mispred_count_q + 32'd1;
    end
  end

`ifdef BP_GSHARE_EN
  always_comb begin
    ghr_d      = ghr_q;
    pred_ghr_d = bp.PredValid ? ghr_q : '0;
    if (bp.ResValid) ghr_d = {ghr_q[IDX_W-2:0], bp.ResTaken};
    // A wrong path rebuilds history from what the branch actually saw.
    if (mispredict_d) ghr_d = {bp.ResGhr[IDX_W-2:0], bp.ResTaken};
  end
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < ENTRIES; i++) table_q[i] <= INIT_STATE;
      pred_out_valid_q <= 1'b0;
      pred_taken_q     <= 1'b0;
      mispredict_q     <= 1'b0;
      mispred_count_q  <= '0;
`ifdef BP_GSHARE_EN
      ghr_q            <= '0;
      pred_ghr_q       <= '0;
`endif
    end else begin
      for (int i = 0; i < ENTRIES; i++) table_q[i] <= table_d[i];
      pred_out_valid_q <= pred_out_valid_d;
      pred_taken_q     <= pred_taken_d;
      mispredict_q     <= mispredict_d;
      mispred_count_q  <= mispred_count_d;
`ifdef BP_GSHARE_EN
      ghr_q            <= ghr_d;
      pred_ghr_q       <= pred_ghr_d;
`endif
    end
  end

  assign bp.PredOutValid = pred_out_valid_q;
  assign bp.PredTaken    = pred_taken_q;
  assign bp.Mispredict   = mispredict_q;
  assign bp.MispredCount = mispred_count_q;
`ifdef BP_GSHARE_EN
  assign bp.PredGhr      = pred_ghr_q;
`endif

  logic unused_pc_bits;
  assign unused_pc_bits = ^{bp.PredPC[XLEN-1:IDX_W+2], bp.PredPC[1:0],
                            bp.ResPC[XLEN-1:IDX_W+2],  bp.ResPC[1:0]};

endmodule

// File: tb/tb_branch_predictor.sv
// tb/tb_branch_predictor.sv - scoreboard bench for branch_predictor (default bimodal build)
module tb_branch_predictor;
  logic clk;
  logic rst;

  branch_predictor_if #(.XLEN(64), .IDX_W(6)) bp ();

  branch_predictor #(.XLEN(64), .IDX_W(6), .INIT_STATE(2'b01)) dut (
    .clk (clk),
    .rst (rst),
    .bp  (bp)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int unsigned n_total = 0;
  int unsigned n_pass  = 0;
  logic        mon_en  = 1'b0;

  logic        pred_q [$];
  logic [31:0] mis_q  [$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", name, act, exp);
  endtask

  task automatic idle_inputs();
    bp.PredValid    = 1'b0;
    bp.PredPC       = '0;
    bp.ResValid     = 1'b0;
    bp.ResPC        = '0;
    bp.ResTaken     = 1'b0;
    bp.ResPredTaken = 1'b0;
`ifdef BP_GSHARE_EN
    bp.ResGhr       = '0;
`endif
  endtask

  // One cycle of stimulus; expectations go to the scoreboard queues.
  task automatic drive(input logic pv, input logic [63:0] ppc, input logic ept,
                       input logic rv, input logic [63:0] rpc, input logic rt,
                       input logic rpt, input logic [31:0] ecnt);
    bp.PredValid    = pv;
    bp.PredPC       = ppc;
    bp.ResValid     = rv;
    bp.ResPC        = rpc;
    bp.ResTaken     = rt;
    bp.ResPredTaken = rpt;
    if (pv) pred_q.push_back(ept);
    if (rv && (rt != rpt)) mis_q.push_back(ecnt);
    @(posedge clk);
    #1;
    idle_inputs();
  endtask

  always @(negedge clk) begin
    if (mon_en) begin
      if (bp.PredOutValid) begin
        if (pred_q.size() == 0) check("pred_unexpected", {31'b0, bp.PredOutValid}, 32'd0);
        else check("pred_taken", {31'b0, bp.PredTaken}, {31'b0, pred_q.pop_front()});
      end
      if (bp.Mispredict) begin
        if (mis_q.size() == 0) check("mispredict_unexpected", {31'b0, bp.Mispredict}, 32'd0);
        else check("mispred_count", bp.MispredCount, mis_q.pop_front());
      end
    end
  end

  initial begin
    idle_inputs();
    rst = 1'b1;
    @(posedge clk);
    #1;
    // Traffic during reset must be dropped.
    bp.PredValid    = 1'b1;
    bp.PredPC       = 64'h100;
    bp.ResValid     = 1'b1;
    bp.ResPC        = 64'h100;
    bp.ResTaken     = 1'b1;
    bp.ResPredTaken = 1'b0;
    @(posedge clk);
    #1;
    rst = 1'b0;
    idle_inputs();
    mon_en = 1'b1;
    @(negedge clk);
    check("rst_pred_out_valid", {31'b0, bp.PredOutValid}, 32'd0);
    check("rst_pred_taken",     {31'b0, bp.PredTaken},    32'd0);
    check("rst_mispredict",     {31'b0, bp.Mispredict},   32'd0);
    check("rst_mispred_count",  bp.MispredCount,          32'd0);
    @(posedge clk);
    #1;

    drive(1, 64'h100, 0,  0, 64'h0,   0, 0, 0);
    drive(0, 64'h0,   0,  1, 64'h100, 1, 0, 32'd1);
    drive(0, 64'h0,   0,  1, 64'h100, 1, 1, 0);
    drive(1, 64'h100, 1,  0, 64'h0,   0, 0, 0);
    drive(1, 64'h100, 1,  1, 64'h100, 1, 1, 0);
    drive(0, 64'h0,   0,  1, 64'h100, 0, 1, 32'd2);
    drive(1, 64'h100, 1,  0, 64'h0,   0, 0, 0);
    drive(0, 64'h0,   0,  1, 64'h100, 0, 1, 32'd3);
    drive(1, 64'h100, 0,  0, 64'h0,   0, 0, 0);
    drive(1, 64'h103, 0,  1, 64'h104, 1, 0, 32'd4);
    drive(1, 64'h200, 0,  0, 64'h0,   0, 0, 0);
    drive(1, 64'h104, 1,  0, 64'h0,   0, 0, 0);
    drive(1, 64'h100, 1,  1, 64'h100, 1, 0, 32'd5);
    drive(1, 64'h100, 0,  1, 64'h100, 0, 0, 0);

    bp.PredValid = 1'b0;
    bp.PredPC    = 'x;
    @(posedge clk);
    #1;
    idle_inputs();
    @(negedge clk);
    check("x_pc_pred_out_valid", {31'b0, bp.PredOutValid}, 32'd0);
    check("x_pc_pred_taken",     {31'b0, bp.PredTaken},    32'd0);
    @(posedge clk);
    #1;

    force dut.mispred_count_q = 32'hFFFF_FFFE;
    #1;
    release dut.mispred_count_q;
    check("count_preload", bp.MispredCount, 32'hFFFF_FFFE);
    drive(0, 64'h0, 0, 1, 64'h100, 1, 0, 32'hFFFF_FFFF);
    drive(0, 64'h0, 0, 1, 64'h100, 1, 0, 32'hFFFF_FFFF);

    drive(0, 64'h0,   0,  1, 64'h104, 1, 1, 0);
    drive(1, 64'h104, 1,  0, 64'h0,   0, 0, 0);

    bp.ResValid     = 1'b1;
    bp.ResPC        = 64'h104;
    bp.ResTaken     = 1'b0;
    bp.ResPredTaken = 1'b1;
    rst             = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    idle_inputs();
    @(negedge clk);
    check("midrst_mispred_count", bp.MispredCount,          32'd0);
    check("midrst_mispredict",    {31'b0, bp.Mispredict},   32'd0);
    check("midrst_pred_valid",    {31'b0, bp.PredOutValid}, 32'd0);
    @(posedge clk);
    #1;
    drive(1, 64'h104, 0, 0, 64'h0, 0, 0, 0);
    drive(1, 64'h100, 0, 0, 64'h0, 0, 0, 0);

    repeat (3) @(posedge clk);
    @(negedge clk);
    check("pred_queue_drained",     pred_q.size(), 32'd0);
    check("mispred_queue_drained",  mis_q.size(),  32'd0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/branch_predictor.md
Name: branch_predictor

Overview:
- Fetch-side consumer of the branch_operator `result`: a bimodal predictor built from a table of 2-bit saturating counters.
- Fetch queries it with a PC and gets a registered taken/not-taken prediction.
- Execute returns the resolved outcome: branch_operator `result` plus the prediction that was made.
- The block updates the counter, flags mispredictions for the PC-redirect logic, and counts them.

Parameters:
- XLEN, 64, PC width in bits.
- IDX_W, 6, table index width; the table has 2**IDX_W entries.
- INIT_STATE, 2'b01, counter value every entry takes on reset (weakly not-taken).

Ports:
- clk  input  1  rising-edge clock
- rst  input  1  synchronous reset, active-high
- PredValid  input  1  prediction request this cycle
- PredPC  input  XLEN  PC of the branch being fetched
- PredOutValid  output  1  registered; PredTaken is valid
- PredTaken  output  1  registered prediction; 1 = taken
- ResValid  input  1  a resolved branch is presented this cycle
- ResPC  input  XLEN  PC of the resolved branch
- ResTaken  input  1  actual outcome (branch_operator result)
- ResPredTaken  input  1  prediction originally issued for this branch
- Mispredict  output  1  registered one-cycle pulse
- MispredCount  output  32  saturating count of mispredictions

Behaviour:
- Reset (rst=1 sampled at a clk edge), all values from the following cycle:
  - every table entry = INIT_STATE
  - PredOutValid=0, PredTaken=0, Mispredict=0, MispredCount=0
  - any request or resolve presented in the reset cycle is discarded
- Index: PC[IDX_W+1:2]. Instructions are 4-byte aligned; PC[1:0] is ignored. Aliasing between PCs sharing an index is permitted.
- Counter encoding: 00 SNT, 01 WNT, 10 WT, 11 ST. Prediction = counter[1].
- Update on ResValid:
  - ResTaken=1: counter increments, saturating at 11.
  - ResTaken=0: counter decrements, saturating at 00.
  - The new value is written at the end of the same cycle.
- Prediction latency is 1 cycle: PredValid in cycle N gives PredOutValid=1 and PredTaken in cycle N+1. PredOutValid=0 whenever PredValid was 0 in the previous cycle.
- Simultaneous events:
  - PredValid and ResValid in the same cycle with the same index: the prediction uses the post-update counter (write-first bypass).
  - Different indices: fully independent.
- Mispredict:
  - Set in cycle N+1 to ResValid & (ResTaken != ResPredTaken) sampled in cycle N; 0 otherwise.
  - MispredCount increments in the same cycle Mispredict goes high.
  - MispredCount holds at 32'hFFFF_FFFF and does not wrap.
- Back-to-back resolves to the same index every cycle each apply to the previously updated value; no update is lost.
- X on PredPC while PredValid=0 must not propagate to any output.

Optional Feature:
- Macro BP_GSHARE_EN.
- When defined:
  - Adds a global history register GHR, IDX_W bits wide, reset to 0.
  - Prediction index = PC[IDX_W+1:2] XOR GHR.
  - Adds output PredGhr (IDX_W bits), registered alongside PredTaken, holding the GHR used for the prediction.
  - Adds input ResGhr (IDX_W bits); update index = ResPC[IDX_W+1:2] XOR ResGhr.
  - On ResValid: GHR <= {GHR[IDX_W-2:0], ResTaken}.
  - A same-cycle prediction uses the pre-shift GHR.
  - On Mispredict the GHR is repaired to {ResGhr[IDX_W-2:0], ResTaken}.
- When not defined: pure bimodal indexing; the PredGhr and ResGhr ports do not exist.

Decomposition:
- Package bp_pkg holds:
  - counter state constants CTR_SNT, CTR_WNT, CTR_WT, CTR_ST
  - the 2-bit counter typedef
  - the MispredCount saturation constant
- Sub-module sat_counter2: purely combinational next-state function (cur, taken -> next). Instantiated once on the update path.

Test Plan:
- Reset: rst=1 one cycle, then PredValid with PredPC=0x100 -> PredTaken=0 at N+1 (INIT 01), Mispredict=0, MispredCount=0.
- Training: 2 resolves on PC=0x100 with ResTaken=1 -> entry 01->10->11; next prediction on 0x100 gives PredTaken=1. A third taken resolve keeps the entry at 11 (saturation).
- Hysteresis: from 11, one ResTaken=0 resolve -> 10, still predicts taken. A second -> 01, predicts not-taken.
- Bypass: entry at 01; same cycle PredValid PC=0x100 and ResValid PC=0x100 ResTaken=1 -> PredTaken=1 at N+1.
- Mispredict: ResTaken=1, ResPredTaken=0 -> Mispredict=1 for exactly one cycle and MispredCount 0->1. Matching outcome -> no pulse. Force the count to 32'hFFFF_FFFF, inject a mispredict -> count stays at 32'hFFFF_FFFF.
- Reset mid-operation: train PC=0x104 to 11, assert rst in the same cycle as a ResValid -> entry reads back 01, MispredCount=0. With BP_GSHARE_EN, GHR=0 after reset.
